banco_registros_param: RTL and testbench

Parametrised register bank: next generation of the general-purpose register file for the single-cycle datapath. Writes are synchronous, and the two read ports are combinational with same-cycle write bypass. A built-in clear sequencer zeroes the whole bank, one entry per clock, under a single command. Sits between the decode stage (addresses) and the ALU/writeback path (data).

---
 rtl/banco_registros_param_if.sv | 28 ++
 rtl/banco_registros_param.sv | 146 ++++++++++++++
 tb/tb_banco_registros_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/banco_registros_param_if.sv
// banco_registros_param_if: bus between decode/writeback and the register bank.
// Decode and writeback drive the address, data and command signals (master).
// The bank returns the read data and status (slave).
interface banco_registros_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] RA1_BANCO;
  logic [ADDR_W-1:0] RA2_BANCO;
  logic [ADDR_W-1:0] WA_BANCO;
  logic [DATA_W-1:0] DW_BANCO;
  logic              WE_BANCO;
  logic              CLR_BANCO;
  logic [DATA_W-1:0] DR1_BANCO;
  logic [DATA_W-1:0] DR2_BANCO;
  logic              BUSY_BANCO;
  logic              WERR_BANCO;

  modport master (
    output RA1_BANCO, RA2_BANCO, WA_BANCO, DW_BANCO, WE_BANCO, CLR_BANCO,
    input  DR1_BANCO, DR2_BANCO, BUSY_BANCO, WERR_BANCO
  );

  modport slave (
    input  RA1_BANCO, RA2_BANCO, WA_BANCO, DW_BANCO, WE_BANCO, CLR_BANCO,
    output DR1_BANCO, DR2_BANCO, BUSY_BANCO, WERR_BANCO
  );
endinterface

// File: rtl/banco_registros_param.sv
// banco_registros_param: 2R/1W register bank with a synchronous write port.
// Both read ports are combinational and see a write in the same cycle through a bypass path.
// A clear sequencer zeroes the bank one entry per clock.
// Optional feature: define ZERO_REG_EN to hardwire entry 0 to zero.

// One read port. It selects, in priority order: the hardwired zero entry, the in-flight write data, then the array.
module banco_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [DATA_W-1:0] i_q,
  input  logic              i_byp_en,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_dw,
  output logic [DATA_W-1:0] o_dr
);
  logic w_ra_zero;
  logic w_hit;

`ifdef ZERO_REG_EN
  assign w_ra_zero = (i_ra == '0);
`else
  assign w_ra_zero = 1'b0;
`endif

  assign w_hit = i_byp_en && (i_wa == i_ra);

  // Read mux: zero entry, then bypass, then stored value.
  always_comb begin
    o_dr = i_q;
    if (w_ra_zero)  o_dr = '0;
    else if (w_hit) o_dr = i_dw;
  end
endmodule

module banco_registros_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     CLK_BANCO,
  input  logic                     RSTN_BANCO,
  banco_registros_param_if.slave   bus
);
  localparam int DEPTH     = 2**ADDR_W;
  localparam int NUM_PORTS = 2;

  typedef enum logic {S_IDLE, S_CLEARING} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt,   w_cnt_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_werr,  w_werr_nxt;
  logic              w_wr_en;   // write commits at this edge (also enables bypass)
  logic              w_clr_en;  // clear entry r_cnt at this edge
  logic              w_we_zero; // write targets the hardwired zero entry

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_ra;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_dr;

`ifdef ZERO_REG_EN
  assign w_we_zero = (bus.WA_BANCO == '0);
`else
  assign w_we_zero = 1'b0;
`endif

  // Next-state logic. Writes addressed to the zero entry vanish silently, so they never raise WERR.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_werr_nxt  = 1'b0;
    w_wr_en     = 1'b0;
    w_clr_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.CLR_BANCO) begin
          w_state_nxt = S_CLEARING;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_werr_nxt  = bus.WE_BANCO && !w_we_zero;
        end else if (bus.WE_BANCO && !w_we_zero) begin
          w_wr_en = 1'b1;
        end
      end
      S_CLEARING: begin
        w_clr_en   = 1'b1;
        w_cnt_nxt  = r_cnt + 1'b1;  // wraps to 0 together with the return to IDLE
        w_werr_nxt = bus.WE_BANCO && !w_we_zero;
        if (r_cnt == ADDR_W'(DEPTH-1)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state register. Reset aborts any clear in progress, and the clear does not resume.
  always_ff @(posedge CLK_BANCO or negedge RSTN_BANCO) begin
    if (!RSTN_BANCO) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_werr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_werr  <= w_werr_nxt;
    end
  end

  // Storage array. A write and a clear are mutually exclusive by state.
  always_ff @(posedge CLK_BANCO or negedge RSTN_BANCO) begin
    if (!RSTN_BANCO) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.WA_BANCO] <= bus.DW_BANCO;
    end else if (w_clr_en) begin
      r_mem[r_cnt] <= '0;
    end
  end

  assign w_ra = {bus.RA2_BANCO, bus.RA1_BANCO};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    assign w_q[p] = r_mem[w_ra[p]];
    banco_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .i_ra     (w_ra[p]),
      .i_q      (w_q[p]),
      .i_byp_en (w_wr_en),
      .i_wa     (bus.WA_BANCO),
      .i_dw     (bus.DW_BANCO),
      .o_dr     (w_dr[p])
    );
  end

  assign bus.DR1_BANCO  = w_dr[0];
  assign bus.DR2_BANCO  = w_dr[1];
  assign bus.BUSY_BANCO = r_busy;
  assign bus.WERR_BANCO = r_werr;
endmodule

// File: tb/tb_banco_registros_param.sv
// tb_banco_registros_param: directed vectors for banco_registros_param.
// The expected results for the address-0 write depend on whether ZERO_REG_EN is defined.
module tb_banco_registros_param;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt;

  banco_registros_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  banco_registros_param #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK_BANCO  (clk),
    .RSTN_BANCO (rstn),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle. Count BUSY cycles along the way.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.BUSY_BANCO === 1'b1) busy_cnt++;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.WE_BANCO = 1'b1; bus.WA_BANCO = a; bus.DW_BANCO = d;
    tick();
    bus.WE_BANCO = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] a, output logic [31:0] d);
    bus.RA1_BANCO = a;
    #1;
    d = bus.DR1_BANCO;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp0;
    bus.RA1_BANCO = '0; bus.RA2_BANCO = '0; bus.WA_BANCO = '0;
    bus.DW_BANCO  = '0; bus.WE_BANCO  = 1'b0; bus.CLR_BANCO = 1'b0;
    busy_cnt = 0;

    // Reset state
    #12;
    chk("rst_dr1",  bus.DR1_BANCO, 32'h0);
    chk("rst_dr2",  bus.DR2_BANCO, 32'h0);
    chk("rst_busy", {31'h0, bus.BUSY_BANCO}, 32'h0);
    chk("rst_werr", {31'h0, bus.WERR_BANCO}, 32'h0);
    rstn = 1'b1;
    tick();

    // Bypass on port 1, unrelated address on port 2
    bus.RA1_BANCO = 5; bus.RA2_BANCO = 6;
    bus.WE_BANCO = 1'b1; bus.WA_BANCO = 5; bus.DW_BANCO = 32'hDEADBEEF;
    #1;
    chk("byp_dr1", bus.DR1_BANCO, 32'hDEADBEEF);
    chk("byp_dr2", bus.DR2_BANCO, 32'h0);
    tick();
    bus.WE_BANCO = 1'b0;
    #1;
    chk("wr5_after", bus.DR1_BANCO, 32'hDEADBEEF);
    chk("wr5_werr",  {31'h0, bus.WERR_BANCO}, 32'h0);

    // Bypass on both ports at once
    bus.RA1_BANCO = 7; bus.RA2_BANCO = 7;
    bus.WE_BANCO = 1'b1; bus.WA_BANCO = 7; bus.DW_BANCO = 32'h1234;
    #1;
    chk("byp2_dr1", bus.DR1_BANCO, 32'h1234);
    chk("byp2_dr2", bus.DR2_BANCO, 32'h1234);
    tick();
    bus.WE_BANCO = 1'b0;
    #1;
    chk("wr7_dr1", bus.DR1_BANCO, 32'h1234);
    chk("wr7_dr2", bus.DR2_BANCO, 32'h1234);

    // Fill addr*3, then run a full clear
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 3));
    rd1(5'd17, v); chk("fill17", v, 32'd51);
    busy_cnt = 0;
    bus.CLR_BANCO = 1'b1;
    tick();                       // CLR edge
    bus.CLR_BANCO = 1'b0;
    chk("clr_busy", {31'h0, bus.BUSY_BANCO}, 32'h1);
    repeat (10) tick();           // entries 0..9 cleared
    bus.RA1_BANCO = 9; bus.RA2_BANCO = 10;
    #1;
    chk("mid_a9",  bus.DR1_BANCO, 32'h0);
    chk("mid_a10", bus.DR2_BANCO, 32'd30);
    // A write during the clear is dropped and gets no bypass.
    bus.RA1_BANCO = 31;
    bus.WE_BANCO = 1'b1; bus.WA_BANCO = 31; bus.DW_BANCO = 32'hFFFF;
    #1;
    chk("clr_nobyp", bus.DR1_BANCO, 32'd93);
    tick();
    bus.WE_BANCO = 1'b0;
    chk("clr_werr1", {31'h0, bus.WERR_BANCO}, 32'h1);
    chk("clr_a31_keep", bus.DR1_BANCO, 32'd93);
    tick();
    chk("clr_werr0", {31'h0, bus.WERR_BANCO}, 32'h0);
    for (int i = 0; i < 64 && bus.BUSY_BANCO === 1'b1; i++) tick();
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    chk("busy_done", {31'h0, bus.BUSY_BANCO}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd1(5'(i), v);
      chk($sformatf("post_clr_a%0d", i), v, 32'h0);
    end

    // Reset in the middle of a clear, with WERR high
    wr(5'd20, 32'h77);
    bus.CLR_BANCO = 1'b1;
    tick();
    bus.CLR_BANCO = 1'b0;
    repeat (3) tick();
    bus.WE_BANCO = 1'b1; bus.WA_BANCO = 2; bus.DW_BANCO = 32'h5;
    tick();
    bus.WE_BANCO = 1'b0;
    chk("pre_rst_werr", {31'h0, bus.WERR_BANCO}, 32'h1);
    rd1(5'd20, v); chk("pre_rst_a20", v, 32'h77);
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, bus.BUSY_BANCO}, 32'h0);
    chk("rst_mid_werr", {31'h0, bus.WERR_BANCO}, 32'h0);
    rd1(5'd20, v); chk("rst_mid_a20", v, 32'h0);
    #3 rstn = 1'b1;
    wr(5'd3, 32'hA5A5);
    rd1(5'd3, v); chk("post_rst_a3", v, 32'hA5A5);
    chk("post_rst_busy", {31'h0, bus.BUSY_BANCO}, 32'h0);

    // Write to address 0
`ifdef ZERO_REG_EN
    exp0 = 32'h0;
`else
    exp0 = 32'hABCD;
`endif
    bus.RA1_BANCO = 0;
    bus.WE_BANCO = 1'b1; bus.WA_BANCO = 0; bus.DW_BANCO = 32'hABCD;
    #1;
    chk("a0_byp", bus.DR1_BANCO, exp0);
    tick();
    bus.WE_BANCO = 1'b0;
    #1;
    chk("a0_after", bus.DR1_BANCO, exp0);
    chk("a0_werr",  {31'h0, bus.WERR_BANCO}, 32'h0);

    // CLR and WE at the same IDLE edge: the write is dropped and WERR is raised.
    bus.RA1_BANCO = 4;
    bus.CLR_BANCO = 1'b1; bus.WE_BANCO = 1'b1; bus.WA_BANCO = 4; bus.DW_BANCO = 32'h99;
    #1;
    chk("clrwe_nobyp", bus.DR1_BANCO, 32'h0);
    busy_cnt = 0;
    tick();
    bus.CLR_BANCO = 1'b0; bus.WE_BANCO = 1'b0;
    chk("clrwe_werr", {31'h0, bus.WERR_BANCO}, 32'h1);
    chk("clrwe_busy", {31'h0, bus.BUSY_BANCO}, 32'h1);
    for (int i = 0; i < 64 && bus.BUSY_BANCO === 1'b1; i++) tick();
    chk("clrwe_cycles", 32'(busy_cnt), 32'd32);
    rd1(5'd4, v); chk("clrwe_a4", v, 32'h0);
    rd1(5'd3, v); chk("clrwe_a3", v, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
